// File: rtl/crossbar_2x2_top.sv
// 2x2 req/ack crossbar: addr[31] selects the slave, round-robin per slave, 0-cycle ack/rdata return.
// Optional debug ports (rsent0/1, req_stat0/1) enabled by defining CROSSBAR_DEBUG_EN.
module crossbar_2x2_top (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        master_0_req,
  input  logic        master_0_cmd,
  input  logic [31:0] master_0_addr,
  input  logic [31:0] master_0_wdata,
  output logic [31:0] master_0_rdata,
  output logic        master_0_ack,
  input  logic        master_1_req,
  input  logic        master_1_cmd,
  input  logic [31:0] master_1_addr,
  input  logic [31:0] master_1_wdata,
  output logic [31:0] master_1_rdata,
  output logic        master_1_ack,
  output logic        slave_0_cmd,
  output logic [31:0] slave_0_addr,
  output logic [31:0] slave_0_wdata,
  input  logic [31:0] slave_0_rdata,
  input  logic        slave_0_ack,
  output logic        slave_1_cmd,
  output logic [31:0] slave_1_addr,
  output logic [31:0] slave_1_wdata,
  input  logic [31:0] slave_1_rdata,
  input  logic        slave_1_ack
`ifdef CROSSBAR_DEBUG_EN
  ,
  output logic        rsent0,
  output logic        rsent1,
  output logic [1:0]  req_stat0,
  output logic [1:0]  req_stat1
`endif
);

  typedef enum logic [1:0] {IDLE = 2'b00, GNT_M0 = 2'b01, GNT_M1 = 2'b10} gnt_e;

  logic [1:0]       m_req, m_cmd, m_tgt, s_ack;
  logic [1:0][31:0] m_addr, m_wdata, s_rdata;
  logic [1:0][1:0]  req_s;  // req_s[slave][master]

  assign m_req   = {master_1_req, master_0_req};
  assign m_cmd   = {master_1_cmd, master_0_cmd};
  assign m_addr  = {master_1_addr, master_0_addr};
  assign m_wdata = {master_1_wdata, master_0_wdata};
  assign m_tgt   = {master_1_addr[31], master_0_addr[31]};
  assign s_ack   = {slave_1_ack, slave_0_ack};
  assign s_rdata = {slave_1_rdata, slave_0_rdata};
  assign req_s[0] = m_req & ~m_tgt;
  assign req_s[1] = m_req & m_tgt;

  gnt_e       state_q [2];
  gnt_e       state_d [2];
  logic [1:0] last_q, last_d;

  // last_served resets to master 1 so master 0 wins the first conflict
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q[0] <= IDLE;
      state_q[1] <= IDLE;
      last_q     <= 2'b11;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      last_q     <= last_d;
    end
  end

  always_comb begin
    state_d[0] = state_q[0];
    state_d[1] = state_q[1];
    last_d     = last_q;
    for (int s = 0; s < 2; s++) begin
      case (state_q[s])
        IDLE: begin
          if (req_s[s][0] && req_s[s][1]) state_d[s] = last_q[s] ? GNT_M0 : GNT_M1;
          else if (req_s[s][0])           state_d[s] = GNT_M0;
          else if (req_s[s][1])           state_d[s] = GNT_M1;
        end
        GNT_M0: if (s_ack[s]) begin
          state_d[s] = IDLE;
          last_d[s]  = 1'b0;
        end
        GNT_M1: if (s_ack[s]) begin
          state_d[s] = IDLE;
          last_d[s]  = 1'b1;
        end
        default: state_d[s] = IDLE;
      endcase
    end
  end

  logic [1:0]       s_cmd, mo_ack;
  logic [1:0][31:0] s_addr, s_wdata, mo_rdata;

  // A master targets only one slave at a time, so OR-merging the returns is safe
  always_comb begin
    s_cmd    = '0;
    s_addr   = '0;
    s_wdata  = '0;
    mo_ack   = '0;
    mo_rdata = '0;
    for (int s = 0; s < 2; s++) begin
      case (state_q[s])
        GNT_M0: begin
          s_cmd[s]    = m_cmd[0];
          s_addr[s]   = m_addr[0];
          s_wdata[s]  = m_wdata[0];
          mo_ack[0]   = mo_ack[0] | s_ack[s];
          mo_rdata[0] = mo_rdata[0] | s_rdata[s];
        end
        GNT_M1: begin
          s_cmd[s]    = m_cmd[1];
          s_addr[s]   = m_addr[1];
          s_wdata[s]  = m_wdata[1];
          mo_ack[1]   = mo_ack[1] | s_ack[s];
          mo_rdata[1] = mo_rdata[1] | s_rdata[s];
        end
        default: ;
      endcase
    end
  end

  assign slave_0_cmd    = s_cmd[0];
  assign slave_0_addr   = s_addr[0];
  assign slave_0_wdata  = s_wdata[0];
  assign slave_1_cmd    = s_cmd[1];
  assign slave_1_addr   = s_addr[1];
  assign slave_1_wdata  = s_wdata[1];
  assign master_0_ack   = mo_ack[0];
  assign master_0_rdata = mo_rdata[0];
  assign master_1_ack   = mo_ack[1];
  assign master_1_rdata = mo_rdata[1];

`ifdef CROSSBAR_DEBUG_EN
  assign rsent0    = (state_q[0] == GNT_M0) || (state_q[1] == GNT_M0);
  assign rsent1    = (state_q[0] == GNT_M1) || (state_q[1] == GNT_M1);
  assign req_stat0 = state_q[0];
  assign req_stat1 = state_q[1];
`endif

endmodule

// File: tb/tb_crossbar_2x2_top.sv
// Directed bench for crossbar_2x2_top with an expected-grant scoreboard queue.
module tb_crossbar_2x2_top;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_req [2];
  logic        m_cmd [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_rdata [2];
  logic        m_ack [2];
  logic        s_cmd [2];
  logic [31:0] s_addr [2];
  logic [31:0] s_wdata [2];
  logic [31:0] s_rdata [2];
  logic        s_ack [2];
`ifdef CROSSBAR_DEBUG_EN
  logic        rsent0, rsent1;
  logic [1:0]  req_stat0, req_stat1;
`endif

  int n_asrt = 0;
  int n_fail = 0;

  typedef struct {
    int          slv;
    int          mst;
    logic        cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;
  txn_t sb[$];

  always #5 clk = ~clk;

  crossbar_2x2_top dut (
`ifdef CROSSBAR_DEBUG_EN
    .rsent0(rsent0), .rsent1(rsent1), .req_stat0(req_stat0), .req_stat1(req_stat1),
`endif
    .clk(clk), .rst_n(rst_n),
    .master_0_req(m_req[0]), .master_0_cmd(m_cmd[0]), .master_0_addr(m_addr[0]),
    .master_0_wdata(m_wdata[0]), .master_0_rdata(m_rdata[0]), .master_0_ack(m_ack[0]),
    .master_1_req(m_req[1]), .master_1_cmd(m_cmd[1]), .master_1_addr(m_addr[1]),
    .master_1_wdata(m_wdata[1]), .master_1_rdata(m_rdata[1]), .master_1_ack(m_ack[1]),
    .slave_0_cmd(s_cmd[0]), .slave_0_addr(s_addr[0]), .slave_0_wdata(s_wdata[0]),
    .slave_0_rdata(s_rdata[0]), .slave_0_ack(s_ack[0]),
    .slave_1_cmd(s_cmd[1]), .slave_1_addr(s_addr[1]), .slave_1_wdata(s_wdata[1]),
    .slave_1_rdata(s_rdata[1]), .slave_1_ack(s_ack[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a master request and record the grant it should eventually receive
  task automatic issue(input int m, input logic cmd, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata);
    txn_t t;
    m_req[m] = 1'b1; m_cmd[m] = cmd; m_addr[m] = addr; m_wdata[m] = wdata;
    t.slv = int'(addr[31]); t.mst = m; t.cmd = cmd; t.addr = addr;
    t.wdata = wdata; t.rdata = rdata;
    sb.push_back(t);
  endtask

  task automatic pop_chk_grant(output txn_t t);
    n_asrt++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("FAIL sb_empty: observed 0 entries expected >0");
    end
    if (sb.size() > 0) begin
      t = sb.pop_front();
      chk("gnt_cmd", 32'(s_cmd[t.slv]), 32'(t.cmd));
      chk("gnt_addr", s_addr[t.slv], t.addr);
      chk("gnt_wdata", s_wdata[t.slv], t.wdata);
      chk("pre_ack", 32'(m_ack[t.mst]), 32'd0);
    end else begin
      t.slv = 0; t.mst = 0; t.cmd = 1'b0; t.addr = '0; t.wdata = '0; t.rdata = '0;
    end
  endtask

  // One cycle after the request: grant must be visible; ack it and check release
  task automatic serve(input logic [1:0] drop);
    txn_t t;
    @(negedge clk);
    pop_chk_grant(t);
    s_ack[t.slv] = 1'b1; s_rdata[t.slv] = t.rdata;
    #1;
    chk("m_ack", 32'(m_ack[t.mst]), 32'd1);
    chk("m_rdata", m_rdata[t.mst], t.rdata);
    chk("other_ack", 32'(m_ack[1 - t.mst]), 32'd0);
    @(negedge clk);
    s_ack[t.slv] = 1'b0; s_rdata[t.slv] = '0;
    if (drop[0]) m_req[0] = 1'b0;
    if (drop[1]) m_req[1] = 1'b0;
    #1;
    chk("rel_addr", s_addr[t.slv], 32'd0);
    chk("rel_cmd", 32'(s_cmd[t.slv]), 32'd0);
    chk("rel_ack", 32'(m_ack[t.mst]), 32'd0);
  endtask

  initial begin
    txn_t t;
    for (int i = 0; i < 2; i++) begin
      m_req[i] = 1'b0; m_cmd[i] = 1'b0; m_addr[i] = '0; m_wdata[i] = '0;
      s_rdata[i] = '0; s_ack[i] = 1'b0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_s0_addr", s_addr[0], 32'd0);
    chk("rst_s1_cmd", 32'(s_cmd[1]), 32'd0);
    chk("rst_m0_ack", 32'(m_ack[0]), 32'd0);
    chk("rst_m1_rdata", m_rdata[1], 32'd0);
`ifdef CROSSBAR_DEBUG_EN
    chk("rst_rsent0", 32'(rsent0), 32'd0);
    chk("rst_req_stat0", 32'(req_stat0), 32'd0);
`endif
    @(negedge clk); rst_n = 1'b1;

    // Conflict on slave 0: M0 read wins, then M1 write
    @(negedge clk);
    issue(0, 1'b0, 32'h0000_ADD0, 32'h0, 32'hFEED_00C0);
    issue(1, 1'b1, 32'h0000_ADD1, 32'h000F_EED1, 32'h1234_5678);
    serve(2'b01);
    serve(2'b10);

    // Parallel: M0 -> slave 1, M1 -> slave 0, acks routed independently
    issue(0, 1'b1, 32'h8000_ADD0, 32'hA5A5_0000, 32'h1111_0000);
    issue(1, 1'b0, 32'h0000_ADD1, 32'h0, 32'h2222_0000);
    @(negedge clk);
    pop_chk_grant(t);
    pop_chk_grant(t);
    s_ack[1] = 1'b1; s_rdata[1] = 32'h1111_0000; s_rdata[0] = 32'h2222_0000;
    #1;
    chk("par_m0_ack", 32'(m_ack[0]), 32'd1);
    chk("par_m1_ack_lo", 32'(m_ack[1]), 32'd0);
    chk("par_m0_rdata", m_rdata[0], 32'h1111_0000);
    chk("par_m1_rdata_held", m_rdata[1], 32'h2222_0000);
    @(negedge clk);
    s_ack[1] = 1'b0; s_rdata[1] = '0; m_req[0] = 1'b0; s_ack[0] = 1'b1;
    #1;
    chk("par_m1_ack", 32'(m_ack[1]), 32'd1);
    chk("par_m0_ack_lo", 32'(m_ack[0]), 32'd0);
    chk("par_s1_idle", s_addr[1], 32'd0);
    @(negedge clk);
    s_ack[0] = 1'b0; s_rdata[0] = '0; m_req[1] = 1'b0;
    #1;
    chk("par_s0_idle", s_addr[0], 32'd0);

    // Round-robin with both requests held: M0, M1, M0, M1
    issue(0, 1'b0, 32'h0000_0010, 32'h0, 32'hAAAA_0001);
    issue(1, 1'b1, 32'h0000_0020, 32'hBBBB_0002, 32'hAAAA_0002);
    sb.push_back(sb[0]);
    sb.push_back(sb[1]);
    serve(2'b00);
    serve(2'b00);
    serve(2'b00);
    serve(2'b11);

    // Stray ack on idle slave 1
    s_ack[1] = 1'b1; s_rdata[1] = 32'hDEAD_BEEF;
    #1;
    chk("stray_m0_ack", 32'(m_ack[0]), 32'd0);
    chk("stray_m1_ack", 32'(m_ack[1]), 32'd0);
    chk("stray_m0_rdata", m_rdata[0], 32'd0);
    @(negedge clk);
    s_ack[1] = 1'b0; s_rdata[1] = '0;
    #1;
    chk("stray_s1_idle", s_addr[1], 32'd0);

    // Make last_served=M0 on slave 0, then grant M1 and reset mid-transaction
    issue(0, 1'b0, 32'h0000_0100, 32'h0, 32'h0000_0100);
    serve(2'b01);
    issue(1, 1'b1, 32'h0000_0200, 32'hCAFE_0001, 32'h0);
    @(negedge clk);
    pop_chk_grant(t);
`ifdef CROSSBAR_DEBUG_EN
    chk("dbg_rsent1", 32'(rsent1), 32'd1);
    chk("dbg_req_stat0", 32'(req_stat0), 32'd2);
`endif
    s_ack[0] = 1'b1; s_rdata[0] = 32'h0000_0055;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_s0_addr", s_addr[0], 32'd0);
    chk("mid_rst_s0_wdata", s_wdata[0], 32'd0);
    chk("mid_rst_s0_cmd", 32'(s_cmd[0]), 32'd0);
    chk("mid_rst_m1_ack", 32'(m_ack[1]), 32'd0);
    chk("mid_rst_m1_rdata", m_rdata[1], 32'd0);
`ifdef CROSSBAR_DEBUG_EN
    chk("mid_rst_rsent1", 32'(rsent1), 32'd0);
    chk("mid_rst_req_stat0", 32'(req_stat0), 32'd0);
`endif
    m_req[1] = 1'b0; s_ack[0] = 1'b0; s_rdata[0] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, 1'b0, 32'h0000_0300, 32'h0, 32'h3333_0000);
    issue(1, 1'b1, 32'h0000_0400, 32'h0000_0077, 32'h4444_0000);
    serve(2'b01);
    serve(2'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
